// File: rtl/mult_pipe_pkg.sv
// Shared definitions for the multi-channel squaring / accumulating pipeline.
package mult_pipe_pkg;

  // Default parameter values used by mult_pipe_mc and its lanes
  localparam int DEF_W      = 4;
  localparam int DEF_CH     = 2;
  localparam int DEF_STAGES = 2;
  localparam int DEF_AW     = 4;

  // Operation requested by an input beat; encoding 3 is reserved and
  // is folded onto MODE_SQUARE at the input of the pipeline
  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_ACCUM  = 2'd1,
    MODE_CLEAR  = 2'd2
  } mode_e;

endpackage

// File: rtl/mult_pipe_lane.sv
// One channel: squaring pipeline, saturating accumulator and result register.
// Valid/stall control comes from the shared controller in mult_pipe_mc.
module mult_pipe_lane
  import mult_pipe_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int STAGES = DEF_STAGES,
  parameter int AW     = DEF_AW,
  localparam int RW    = 2*W + AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          advance,
  input  logic [W-1:0]  operand,
  input  logic          pre_valid,
  input  mode_e         pre_mode,
  output logic [RW-1:0] result
);

  logic [2*W-1:0] sq_in;
  logic [2*W-1:0] pre_prod;
  logic [RW-1:0]  acc_q;
  logic [RW:0]    sum;
  logic [RW-1:0]  sat;

  assign sq_in = (2*W)'(operand) * (2*W)'(operand);

  if (STAGES > 1) begin : g_prod_pipe
    logic [2*W-1:0] prod_q [STAGES-1];

    // Carry the square towards the final stage, moving only when the pipeline advances
    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int i = 0; i < STAGES-1; i++) prod_q[i] <= '0;
      end else if (advance) begin
        prod_q[0] <= sq_in;
        for (int i = 1; i < STAGES-1; i++) prod_q[i] <= prod_q[i-1];
      end
    end

    assign pre_prod = prod_q[STAGES-2];
  end else begin : g_prod_direct
    assign pre_prod = sq_in;
  end

  // Saturating sum of the running accumulator and the incoming square
  always_comb begin
    sum = (RW+1)'(acc_q) + (RW+1)'(pre_prod);
    sat = sum[RW] ? '1 : sum[RW-1:0];
  end

  // Final stage: apply the beat's mode to the accumulator and register the result
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q  <= '0;
      result <= '0;
    end else if (advance && pre_valid) begin
      case (pre_mode)
        MODE_ACCUM: begin
          acc_q  <= sat;
          result <= sat;
        end
        MODE_CLEAR: begin
          acc_q  <= '0;
          result <= '0;
        end
        default: begin
          result <= RW'(pre_prod);
        end
      endcase
    end
  end

endmodule

// File: rtl/mult_pipe_mc.sv
// Multi-channel squaring / accumulating pipeline with valid/ready handshake.
// Owns the global stall, the valid pipeline and the mode pipeline; each
// channel's datapath lives in a mult_pipe_lane instance.
module mult_pipe_mc
  import mult_pipe_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int CH     = DEF_CH,
  parameter int STAGES = DEF_STAGES,
  parameter int AW     = DEF_AW,
  localparam int RW    = 2*W + AW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_mode,
  input  logic [CH*W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*RW-1:0] out_data
);

  logic  advance;
  logic  accept;
  logic  pre_valid;
  mode_e in_mode_n;
  mode_e pre_mode;

  // Whole pipeline moves together whenever the output slot is free or being taken
  assign advance  = !out_valid || out_ready;
  assign in_ready = !rstn || advance;
  assign accept   = rstn && in_valid && in_ready;

  // Reserved encoding behaves as SQUARE so no undefined mode enters the pipe
  always_comb begin
    in_mode_n = (in_mode == 2'd3) ? MODE_SQUARE : mode_e'(in_mode);
  end

  if (STAGES > 1) begin : g_ctrl_pipe
    logic [STAGES-2:0] vld_q;
    mode_e             mode_q [STAGES-1];

    // Valid and mode travel beside the lane data up to the final stage
    always_ff @(posedge clk) begin
      if (!rstn) begin
        vld_q <= '0;
        for (int i = 0; i < STAGES-1; i++) mode_q[i] <= MODE_SQUARE;
      end else if (advance) begin
        vld_q[0]  <= accept;
        mode_q[0] <= in_mode_n;
        for (int i = 1; i < STAGES-1; i++) begin
          vld_q[i]  <= vld_q[i-1];
          mode_q[i] <= mode_q[i-1];
        end
      end
    end

    assign pre_valid = vld_q[STAGES-2];
    assign pre_mode  = mode_q[STAGES-2];
  end else begin : g_ctrl_direct
    assign pre_valid = accept;
    assign pre_mode  = in_mode_n;
  end

  // Output valid is the final-stage valid; it only changes when the pipe advances
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= pre_valid;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    mult_pipe_lane #(
      .W      (W),
      .STAGES (STAGES),
      .AW     (AW)
    ) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .advance   (advance),
      .operand   (in_data[c*W +: W]),
      .pre_valid (pre_valid),
      .pre_mode  (pre_mode),
      .result    (out_data[c*RW +: RW])
    );
  end

endmodule

// File: tb/tb_mult_pipe_mc.sv
// Self-checking bench for mult_pipe_mc with a queue-based reference model.
module tb_mult_pipe_mc;
  import mult_pipe_pkg::*;

  localparam int W      = 4;
  localparam int CH     = 2;
  localparam int STAGES = 2;
  localparam int AW     = 4;
  localparam int RW     = 2*W + AW;
  localparam int MAXV   = (1 << RW) - 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [CH*W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CH*RW-1:0] out_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_low = -1;
  bit chk_en = 1'b0;
  bit saw_stall = 1'b0;
  bit last_acc = 1'b0;

  logic [CH*RW-1:0] exp_q [$];
  int               acc_cyc_q [$];
  int               got0 [$];
  int               model_acc [CH];

  mult_pipe_mc #(
    .W      (W),
    .CH     (CH),
    .STAGES (STAGES),
    .AW     (AW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [CH*W-1:0] d, input logic r);
    in_valid  = v;
    in_mode   = m;
    in_data   = d;
    out_ready = r;
  endtask

  // Reference: squares per channel, saturating accumulators updated in acceptance order
  function automatic logic [CH*RW-1:0] model_beat(input logic [1:0] mode, input logic [CH*W-1:0] data);
    logic [CH*RW-1:0] r;
    int n;
    int sq;
    int v;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      n  = int'(data[c*W +: W]);
      sq = n * n;
      if (mode == 2'd1) begin
        model_acc[c] = (model_acc[c] + sq > MAXV) ? MAXV : model_acc[c] + sq;
        v = model_acc[c];
      end else if (mode == 2'd2) begin
        model_acc[c] = 0;
        v = 0;
      end else begin
        v = sq;
      end
      r[c*RW +: RW] = RW'(v);
    end
    return r;
  endfunction

  // One clock: check outputs against the model, book handshakes, then take the edge
  task automatic step();
    bit hs_now;
    #1;
    if (chk_en) begin
      checkOutput("in_ready", {63'd0, in_ready}, {63'd0, (!rstn || !out_valid || out_ready)});
      if (out_valid) begin
        if (exp_q.size() == 0) checkOutput("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        else checkOutput("out_data", 64'(out_data), 64'(exp_q[0]));
      end
    end
    if (!out_ready) last_low = cyc;
    if (!in_ready) saw_stall = 1'b1;
    last_acc = rstn && in_valid && in_ready;
    hs_now   = rstn && out_valid && out_ready;
    if (hs_now && exp_q.size() > 0) begin
      if (acc_cyc_q[0] > last_low) checkOutput("latency", 64'(cyc - acc_cyc_q[0]), 64'(STAGES));
      got0.push_back(int'(out_data[RW-1:0]));
      void'(exp_q.pop_front());
      void'(acc_cyc_q.pop_front());
    end
    if (last_acc) begin
      exp_q.push_back(model_beat(in_mode, in_data));
      acc_cyc_q.push_back(cyc);
    end
    if (!rstn) begin
      exp_q.delete();
      acc_cyc_q.delete();
      for (int c = 0; c < CH; c++) model_acc[c] = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [1:0] m, input logic [CH*W-1:0] d);
    int k;
    applyStimulus(1'b1, m, d, 1'b1);
    k = 0;
    do begin
      step();
      k++;
    end while (!last_acc && k < 50);
    if (!last_acc) checkOutput("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int k;
    applyStimulus(1'b0, 2'd0, '0, 1'b1);
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      step();
      k++;
    end
    checkOutput("drain_left", 64'(exp_q.size()), 64'd0);
    step();
  endtask

  initial begin
    for (int c = 0; c < CH; c++) model_acc[c] = 0;
    rstn = 1'b0;
    applyStimulus(1'b1, 2'd1, {4'd7, 4'd7}, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    rstn = 1'b1;
    applyStimulus(1'b0, 2'd0, '0, 1'b1);
    chk_en = 1'b1;
    repeat (3) step();

    $display("[TB] square latency");
    applyStimulus(1'b1, 2'd0, {4'd15, 4'd3}, 1'b1);
    step();
    applyStimulus(1'b0, 2'd0, '0, 1'b1);
    checkOutput("square_early_valid", {63'd0, out_valid}, 64'd0);
    step();
    checkOutput("square_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("square_data", 64'(out_data), 64'({12'd225, 12'd9}));
    drain();

    $display("[TB] accumulate saturation");
    send(2'd2, '0);
    drain();
    got0.delete();
    for (int i = 0; i < 20; i++) send(2'd1, {4'd1, 4'd15});
    drain();
    checkOutput("sat_count", 64'(got0.size()), 64'd20);
    if (got0.size() == 20) begin
      checkOutput("sat_beat1", 64'(got0[0]), 64'd225);
      checkOutput("sat_beat18", 64'(got0[17]), 64'd4050);
      checkOutput("sat_beat19", 64'(got0[18]), 64'd4095);
      checkOutput("sat_beat20", 64'(got0[19]), 64'd4095);
    end

    $display("[TB] backpressure stream");
    got0.delete();
    saw_stall = 1'b0;
    begin
      int idx;
      idx = 1;
      for (int t = 0; t < 60 && idx <= 10; t++) begin
        applyStimulus(1'b1, 2'd0, {W'(idx), W'(idx)}, !(t >= 3 && t < 8));
        step();
        if (last_acc) idx++;
      end
    end
    drain();
    checkOutput("bp_in_ready_fell", {63'd0, saw_stall}, 64'd1);
    checkOutput("bp_count", 64'(got0.size()), 64'd10);
    for (int i = 0; i < got0.size() && i < 10; i++)
      checkOutput("bp_value", 64'(got0[i]), 64'((i + 1) * (i + 1)));

    $display("[TB] clear ordering");
    send(2'd2, '0);
    drain();
    got0.delete();
    send(2'd1, {4'd0, 4'd5});
    send(2'd2, {4'd9, 4'd9});
    send(2'd1, {4'd0, 4'd2});
    drain();
    checkOutput("clr_count", 64'(got0.size()), 64'd3);
    if (got0.size() == 3) begin
      checkOutput("clr_first", 64'(got0[0]), 64'd25);
      checkOutput("clr_second", 64'(got0[1]), 64'd0);
      checkOutput("clr_third", 64'(got0[2]), 64'd4);
    end

    $display("[TB] reset mid-operation");
    send(2'd1, {4'd1, 4'd1});
    send(2'd1, {4'd2, 4'd2});
    applyStimulus(1'b1, 2'd1, {4'd7, 4'd7}, 1'b1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    applyStimulus(1'b0, 2'd0, '0, 1'b1);
    checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst_out_data", 64'(out_data), 64'd0);
    repeat (4) step();
    got0.delete();
    send(2'd1, {4'd3, 4'd3});
    drain();
    checkOutput("midrst_count", 64'(got0.size()), 64'd1);
    if (got0.size() == 1) checkOutput("midrst_accum", 64'(got0[0]), 64'd9);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    (CH*W)'($urandom), $urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_pipe_mc.md
MULT_PIPE_MC -- requirements
Module: mult_pipe_mc

Interface
REQ-001 SHALL have parameter W, default 4, meaning per-channel input operand width (2..16).
REQ-002 SHALL have parameter CH, default 2, meaning number of independent channels (1..8).
REQ-003 SHALL have parameter STAGES, default 2, meaning pipeline depth in cycles (1..4).
REQ-004 SHALL have parameter AW, default 4, meaning accumulator guard bits; result width RW = 2*W+AW.
REQ-005 SHALL have port clk, input, 1, meaning clock; all logic on its rising edge.
REQ-006 SHALL have port rstn, input, 1, meaning reset, synchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1, meaning an input beat is offered.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-009 SHALL have port in_mode, input, 2, meaning 0 SQUARE, 1 ACCUM, 2 CLEAR, 3 reserved and treated as SQUARE.
REQ-010 SHALL have port in_data, input, CH*W, meaning channel c operand in bits [c*W +: W], unsigned.
REQ-011 SHALL have port out_valid, output, 1, meaning a result beat is presented.
REQ-012 SHALL have port out_ready, input, 1, meaning the sink accepts the result beat.
REQ-013 SHALL have port out_data, output, CH*RW, meaning channel c result in bits [c*RW +: RW], unsigned.

Function
REQ-014 SHALL accept a beat on a cycle where in_valid and in_ready are both high.
REQ-015 SHALL hold out_valid and out_data stable while out_valid is high and out_ready is low.
REQ-016 SHALL drive in_ready = !out_valid || out_ready. Stall is global: all stages advance together or none advances.
REQ-017 SHALL present an accepted beat on out_valid exactly STAGES cycles after acceptance when out_ready is held high.
REQ-018 SHALL sustain one beat per cycle with no bubbles when in_valid and out_ready are held high.
REQ-019 SHALL, in SQUARE mode, produce per channel n*n, zero-extended to RW, with no accumulator change.
REQ-020 SHALL, in ACCUM mode, set per channel acc = min(acc + n*n, 2^RW-1) and output the new acc value.
REQ-021 SHALL, in CLEAR mode, set all accumulators to 0, output 0 on all channels, and ignore in_data.
REQ-022 SHALL update accumulators only in the final stage, in acceptance order, so back-to-back CLEAR then ACCUM yields 0+n*n.
REQ-023 SHALL keep accumulator state across idle cycles and stalls; a stall never double-counts a beat.
REQ-024 SHALL carry mode and valid through the pipeline alongside the data; bubbles carry valid=0 and never touch accumulators.
REQ-025 SHALL produce no X on any output at any time, including reserved mode 3.

Reset
REQ-026 SHALL, on a clk edge with rstn low, clear all stage valids, out_valid, out_data, and every accumulator to 0.
REQ-027 SHALL drive in_ready high during reset, but beats offered while rstn is low SHALL be discarded.
REQ-028 SHALL drop in-flight beats when reset is asserted mid-operation; none of them reaches the output after reset releases.

Structure
REQ-029 SHALL take the mode enum (SQUARE/ACCUM/CLEAR) and the default parameter values from shared package mult_pipe_pkg.
REQ-030 SHALL instantiate CH copies of sub-module mult_pipe_lane, one per channel. Each lane holds its multiply pipeline, saturating accumulator and per-lane result register.
REQ-031 SHALL keep the valid/stall control and the mode pipeline in mult_pipe_mc, shared by all lanes.

Verification (W=4, CH=2, STAGES=2, AW=4, RW=12)
REQ-032 SHALL cover SQUARE: ch0=3, ch1=15, out_ready=1. Required response: out_valid exactly 2 cycles later with out_data ch0=9, ch1=225.
REQ-033 SHALL cover ACCUM saturation: ch0=15 in ACCUM for 20 consecutive beats. Required response: outputs 225, 450, ..., 4050 on beat 18, then 4095 on beats 19 and 20.
REQ-034 SHALL cover backpressure: a continuous stream of 1..10 with out_ready low for 5 cycles mid-stream. Required response: in_ready falls once the pipeline fills; outputs are 1, 4, 9, ..., 100 in order with none lost or duplicated.
REQ-035 SHALL cover CLEAR ordering: ACCUM 5, then CLEAR, then ACCUM 2, back-to-back. Required response: outputs 25, 0, 4.
REQ-036 SHALL cover reset mid-operation: rstn low for 1 cycle with 2 beats in flight. Required response: out_valid=0 and out_data=0 next cycle, no stale beat afterward, and the next ACCUM 3 outputs 9.
